// File: rtl/fifo_pkg.sv
// Shared types for the flow-controlled FIFO: flow-state encoding and depth derivation.
package fifo_pkg;

  typedef enum logic [2:0] {
    EMPTY    = 3'b001,
    CONTINUE = 3'b010,
    PAUSE    = 3'b100
  } flow_state_e;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/fifo_fc_if.sv
// Bus between a packet source (master) and the FIFO (slave): data, requests, thresholds, status.
interface fifo_fc_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
);
  logic [DW-1:0] data_in;
  logic          push;
  logic          pop;
  logic          err_clear;
  logic [AW:0]   umbral_almost_full;
  logic [AW:0]   umbral_almost_empty;

  logic [DW-1:0] data_out_c;
  logic          valid_out_c;
  logic [AW:0]   count_c;
  logic          fifo_empty_c;
  logic          fifo_full_c;
  logic          pause_c;
  logic          overflow_c;
  logic          underflow_c;
  logic          error_c;

  modport master (
    output data_in, push, pop, err_clear, umbral_almost_full, umbral_almost_empty,
    input  data_out_c, valid_out_c, count_c, fifo_empty_c, fifo_full_c,
           pause_c, overflow_c, underflow_c, error_c
  );

  modport slave (
    input  data_in, push, pop, err_clear, umbral_almost_full, umbral_almost_empty,
    output data_out_c, valid_out_c, count_c, fifo_empty_c, fifo_full_c,
           pause_c, overflow_c, underflow_c, error_c
  );
endinterface

// File: rtl/ram_dp_c.sv
// Simple dual-port RAM: one write port, one read port with registered read data.
module ram_dp_c
  import fifo_pkg::*;
#(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int unsigned DEPTH = depth_of(AW);

  logic [DW-1:0] mem_q [DEPTH];

  // Array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read returns the pre-write contents when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_q[raddr];
    end
  end
endmodule

// File: rtl/fifo_fc.sv
// Synchronous FIFO with occupancy-based hysteretic pause and sticky overflow/underflow flags.
module fifo_fc
  import fifo_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input logic      clk,
  input logic      reset,
  fifo_fc_if.slave bus
);
  localparam int unsigned DEPTH = depth_of(AW);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned TW    = AW + 2;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  flow_state_e   state_q, state_d;
  logic          empty_q, full_q, valid_q;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          is_empty, is_full;
  logic          push_ok, pop_ok;
  logic          ovf_ev, unf_ev;
  logic [TW-1:0] thr_set, thr_rel, cnt_nxt;
  logic [DW-1:0] rd_data;

  // Accept decisions and next-state values, all from the pre-edge count.
  always_comb begin
    is_empty    = (count_q == '0);
    is_full     = (count_q == CW'(DEPTH));
    pop_ok      = bus.pop & ~is_empty;
    push_ok     = bus.push & (~is_full | pop_ok);
    ovf_ev      = bus.push & ~push_ok;
    unf_ev      = bus.pop & is_empty;

    wr_ptr_d    = wr_ptr_q + AW'(push_ok);
    rd_ptr_d    = rd_ptr_q + AW'(pop_ok);
    count_d     = count_q + CW'(push_ok) - CW'(pop_ok);

    overflow_d  = (overflow_q & ~bus.err_clear) | ovf_ev;
    underflow_d = (underflow_q & ~bus.err_clear) | unf_ev;

    // A zero assert threshold means the FIFO can never reach it.
    thr_set = (bus.umbral_almost_full == '0) ? TW'(DEPTH + 1) : TW'(bus.umbral_almost_full);
    thr_rel = TW'(bus.umbral_almost_empty);
    cnt_nxt = TW'(count_d);

    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (count_d != '0) state_d = CONTINUE;
      end
      CONTINUE: begin
        if (cnt_nxt >= thr_set)    state_d = PAUSE;
        else if (count_d == '0)    state_d = EMPTY;
      end
      PAUSE: begin
        if (cnt_nxt >= thr_set)    state_d = PAUSE;
        else if (count_d == '0)    state_d = EMPTY;
        else if (cnt_nxt <= thr_rel) state_d = CONTINUE;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= EMPTY;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == CW'(DEPTH));
      valid_q     <= pop_ok;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  ram_dp_c #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (push_ok & ~reset),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .re    (pop_ok & ~reset),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign bus.data_out_c   = rd_data;
  assign bus.valid_out_c  = valid_q;
  assign bus.count_c      = count_q;
  assign bus.fifo_empty_c = empty_q;
  assign bus.fifo_full_c  = full_q;
  assign bus.pause_c      = (state_q == PAUSE);
  assign bus.overflow_c   = overflow_q;
  assign bus.underflow_c  = underflow_q;
  assign bus.error_c      = overflow_q | underflow_q;
endmodule

// File: tb/tb_fifo_fc.sv
// Scoreboard bench for fifo_fc: queue-based reference model, per-cycle status and read-data checks.
module tb_fifo_fc;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_fc_if #(.DW(DW), .AW(AW)) bus ();
  fifo_fc #(.DW(DW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int         cyc;
    int         count;
    bit         empty, full, pause, ovf, unf, valid;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] data_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  logic [7:0] model_q[$];
  bit         m_pause, m_ovf, m_unf;
  logic [7:0] m_last;
  int         uaf = 6;
  int         uae = 2;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; model is updated and the expected post-edge state is queued.
  task automatic step(input bit ps, input bit pp, input logic [7:0] d, input bit clr, input bit rst);
    exp_t e;
    int   n, th;
    bit   pop_ok, push_ok;
    @(posedge clk);
    #1;
    reset                   = rst;
    bus.push                = ps;
    bus.pop                 = pp;
    bus.data_in             = d;
    bus.err_clear           = clr;
    bus.umbral_almost_full  = 4'(uaf);
    bus.umbral_almost_empty = 4'(uae);
    n = model_q.size();
    if (rst) begin
      model_q.delete();
      m_pause = 0; m_ovf = 0; m_unf = 0; m_last = 8'h00;
      e.valid = 0;
    end else begin
      pop_ok  = pp && (n > 0);
      push_ok = ps && ((n < DEPTH) || pop_ok);
      e.valid = pop_ok;
      if (pop_ok) begin
        m_last = model_q.pop_front();
        data_q.push_back(m_last);
      end
      if (push_ok) model_q.push_back(d);
      m_ovf = (m_ovf && !clr) || (ps && !push_ok);
      m_unf = (m_unf && !clr) || (pp && n == 0);
      th = (uaf == 0) ? DEPTH + 1 : uaf;
      // Leaving empty never pauses directly; otherwise set wins over release.
      if (n == 0)                        m_pause = 0;
      else if (model_q.size() >= th)     m_pause = 1;
      else if (model_q.size() <= uae)    m_pause = 0;
    end
    e.cyc   = cyc + 1;
    e.count = model_q.size();
    e.empty = (model_q.size() == 0);
    e.full  = (model_q.size() == DEPTH);
    e.pause = m_pause;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.data  = m_last;
    exp_q.push_back(e);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      chk("count",     32'(bus.count_c),      32'(mon_e.count));
      chk("empty",     32'(bus.fifo_empty_c), 32'(mon_e.empty));
      chk("full",      32'(bus.fifo_full_c),  32'(mon_e.full));
      chk("pause",     32'(bus.pause_c),      32'(mon_e.pause));
      chk("overflow",  32'(bus.overflow_c),   32'(mon_e.ovf));
      chk("underflow", 32'(bus.underflow_c),  32'(mon_e.unf));
      chk("error",     32'(bus.error_c),      32'(mon_e.ovf | mon_e.unf));
      chk("valid",     32'(bus.valid_out_c),  32'(mon_e.valid));
      chk("data_hold", 32'(bus.data_out_c),   32'(mon_e.data));
    end
    if (bus.valid_out_c === 1'b1) begin
      if (data_q.size() == 0) begin
        chk("unexpected_valid", 32'(bus.valid_out_c), 32'd0);
      end else begin
        chk("read_data", 32'(bus.data_out_c), 32'(data_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.push = 0; bus.pop = 0; bus.data_in = '0; bus.err_clear = 0;
    bus.umbral_almost_full = 4'(uaf); bus.umbral_almost_empty = 4'(uae);

    step(0, 0, 8'h00, 0, 1);
    // Fill to full and drain in order.
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'hA1 + i), 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0, 0);
    // Hysteresis.
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 8'h00, 0, 0);
    // Overflow then clear.
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h20 + i), 0, 0);
    step(1, 0, 8'hFF, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'h00, 0, 0);
    // Simultaneous push/pop at full and at empty.
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h30 + i), 0, 0);
    step(1, 1, 8'h55, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0, 0);
    step(1, 1, 8'h66, 0, 0);
    step(0, 1, 8'h00, 1, 0);
    // Pointer wrap with occupancy held at 3.
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 0);
    // Reset mid-operation with a push pending, then underflow.
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h50 + i), 0, 0);
    step(1, 0, 8'h77, 0, 1);
    step(0, 1, 8'h00, 0, 0);
    // Randomised traffic, thresholds, clears and resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        uaf = $urandom_range(0, 9);
        uae = $urandom_range(0, 9);
      end
      step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45),
           8'($urandom), bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 99) == 0));
    end
    uaf = 6; uae = 2;
    for (int i = 0; i < 10; i++) step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("exp_queue_drained",  32'(exp_q.size()),  32'd0);
    chk("data_queue_drained", 32'(data_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_fc.md
Name: fifo_fc

Overview:
Parametrised synchronous FIFO with occupancy-based flow control. It generalises the fixed 8-entry FIFO in depth and width, and adds:
- simultaneous push/pop,
- full and count outputs,
- hysteretic pause signalling,
- sticky overflow/underflow errors.

It sits between a packet source and the round-robin/arbiter logic, which uses pause_c and empty_c to gate requests.

Parameters:
- DW, 8, data width in bits.
- AW, 3, address width; DEPTH = 2**AW entries. Count and thresholds are AW+1 bits.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- data_in  in  DW  write data, sampled when push=1
- push  in  1  write request
- pop  in  1  read request
- err_clear  in  1  clears sticky error flags
- umbral_almost_full  in  AW+1  pause-assert threshold, in entries
- umbral_almost_empty  in  AW+1  pause-release threshold, in entries
- data_out_c  out  DW  read data, registered
- valid_out_c  out  1  data_out_c valid this cycle
- count_c  out  AW+1  current occupancy, 0..DEPTH
- fifo_empty_c  out  1  count_c == 0
- fifo_full_c  out  1  count_c == DEPTH
- pause_c  out  1  almost-full flow-control flag, with hysteresis
- overflow_c  out  1  sticky: push attempted while full
- underflow_c  out  1  sticky: pop attempted while empty
- error_c  out  1  overflow_c | underflow_c

Behaviour:
- Reset (reset=1 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, state=EMPTY.
  - Output values: data_out_c=0, valid_out_c=0, fifo_empty_c=1, fifo_full_c=0, pause_c=0, overflow_c=0, underflow_c=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored data; push and pop in that cycle are ignored.
- Accept rules, evaluated on the pre-edge count:
  - push_ok = push & (!full | pop_ok).
  - pop_ok = pop & !empty.
  - Empty with push=pop=1: the push is accepted; the pop is rejected and sets underflow_c.
  - Full with push=pop=1: both are accepted; count is unchanged.
  - Push while full without pop: data is dropped, pointers hold, overflow_c is set.
  - Pop while empty: pointers hold, underflow_c is set, valid_out_c stays 0.
- Pointers: AW bits, wrap modulo DEPTH.
  - wr_ptr advances on push_ok; rd_ptr advances on pop_ok.
  - count += push_ok - pop_ok.
  - Empty and full are derived from count, never from pointer equality.
- Read latency is 1 cycle.
  - On pop_ok at edge N, data_out_c holds mem[rd_ptr] after edge N and valid_out_c=1 for that cycle only.
  - Otherwise valid_out_c=0 and data_out_c holds its last value.
  - Write-then-read of the same entry: a push to an empty FIFO at edge N can be popped at edge N+1. There is no same-cycle bypass.
- All status outputs are registered from next-count and update on the same edge as count.
- Flow FSM, states EMPTY, CONTINUE, PAUSE (next-count = count after the current edge):
  - EMPTY: pause_c=0. Go to CONTINUE when next-count > 0.
  - CONTINUE: go to PAUSE when next-count >= umbral_almost_full. Else go to EMPTY when next-count == 0.
  - PAUSE: pause_c=1. Go to CONTINUE when next-count <= umbral_almost_empty. Go to EMPTY instead if next-count == 0.
  - Set has priority: if umbral_almost_empty >= umbral_almost_full, PAUSE is evaluated set-first and pause_c follows the set condition.
  - umbral_almost_full=0 is treated as DEPTH+1, i.e. never pause.
- Errors are sticky until reset or err_clear=1.
  - An error event in the same cycle as err_clear wins: the flag stays 1.
  - The FIFO keeps operating while error_c=1.
- Thresholds may change at any time and take effect on the next edge.

Decomposition:
- Package fifo_pkg holds:
  - flow-state localparams: EMPTY=3'b001, CONTINUE=3'b010, PAUSE=3'b100;
  - DEPTH derivation from AW.
- One sub-module, ram_dp_c: parametrised (AW, DW) simple dual-port RAM.
  - Write port: we, waddr, wdata.
  - Read port: re, raddr; registered rdata.
  - No reset on the array.
- Top-level fifo_fc contains pointers, count, accept logic, flow FSM and error flags.

Test Plan (DW=8, AW=3, umbral_almost_full=6, umbral_almost_empty=2):
- Reset, then push 0xA1..0xA8 on 8 consecutive cycles, then pop 8 → data_out_c is 0xA1..0xA8 in order, each one cycle after its pop. count_c steps 0..8..0. fifo_full_c=1 at count 8. fifo_empty_c=1 at the end.
- Hysteresis: push 6 → pause_c rises on the edge where count_c=6. Pop 3 (count 3) → pause_c still 1. Pop 1 (count 2) → pause_c=0, state CONTINUE.
- Overflow: fill to 8, push 0xFF without pop → count_c stays 8, overflow_c=1 and error_c=1. A later pop returns the original head, not 0xFF. err_clear=1 → overflow_c=0 next cycle.
- Simultaneous: at count 8, push 0x55 with pop → count_c stays 8, head is popped, 0x55 is stored last. At count 0, push 0x66 with pop → count_c=1, underflow_c=1, valid_out_c=0.
- Wrap-around: 20 cycles of push+pop with count held at 3 → output sequence matches input delayed by 3 pops. No data loss across pointer wrap. pause_c stays 0.
- Reset mid-operation: count 5 with pause_c=0, assert reset with push=1 → next cycle count_c=0, fifo_empty_c=1, error flags 0. A following pop sets underflow_c=1.
